// File: rtl/spi_sensor_responder.sv
// SPI mode-0 slave standing in for the sensor at the far end of the sensor SPI link.
// Takes 16-bit commands {opcode, addr, data}, owns a small config register file and a
// convert counter, and shifts each frame's result out during the following frame.
// SCLK/CS_b/MOSI are oversampled in the system clock domain.
module spi_sensor_responder #(
  parameter int          NUM_REGS = 16,
  parameter logic [7:0]  CHIP_ID  = 8'h5A,
  parameter logic [15:0] ERR_WORD = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK_wire,
  input  logic        CS_b_wire,
  input  logic        MOSI_to_sensor,
  output logic        MISO_from_sensor,
  output logic [15:0] rx_word,
  output logic        frame_done,
  output logic        frame_error,
  output logic [9:0]  sample_cnt
);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    ACTIVE    = 3'd2,
    COMPLETE  = 3'd3,
    PROCESS   = 3'd4,
    ERROR     = 3'd5
  } state_t;

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);
  localparam logic [5:0] ID_ADDR    = 6'd63;

  state_t      state_r, state_next_s;

  // [0] metastability flop, [1] synchronized level, [2] previous level for edge detect
  logic [2:0]  sclk_pipe_r, cs_pipe_r;
  logic [1:0]  mosi_pipe_r;
  logic        sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, cs_high_s, mosi_s;

  logic [15:0] tx_shift_r, rx_shift_r, pending_r, rx_word_r;
  logic [4:0]  bit_cnt_r;
  logic        overrun_r, miso_r, frame_done_r, frame_error_r;
  logic [9:0]  sample_cnt_r;
  logic [7:0]  regs_r [NUM_REGS];

  logic [1:0]  opcode_s;
  logic [5:0]  addr_s;
  logic [7:0]  data_s, rd_val_s;
  logic [15:0] resp_s;
  logic        reg_hit_s, wr_en_s;

  // Input synchronizers; CS_b resets to "low" so a released block must see a genuine
  // high level on the pin before it will accept a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_pipe_r <= 3'b000;
      cs_pipe_r   <= 3'b000;
      mosi_pipe_r <= 2'b00;
    end else begin
      sclk_pipe_r <= {sclk_pipe_r[1:0], SCLK_wire};
      cs_pipe_r   <= {cs_pipe_r[1:0], CS_b_wire};
      mosi_pipe_r <= {mosi_pipe_r[0], MOSI_to_sensor};
    end
  end

  assign sclk_rise_s = sclk_pipe_r[1] & ~sclk_pipe_r[2];
  assign sclk_fall_s = ~sclk_pipe_r[1] & sclk_pipe_r[2];
  assign cs_rise_s   = cs_pipe_r[1] & ~cs_pipe_r[2];
  assign cs_fall_s   = ~cs_pipe_r[1] & cs_pipe_r[2];
  assign cs_high_s   = cs_pipe_r[1];
  assign mosi_s      = mosi_pipe_r[1];

  assign opcode_s  = rx_shift_r[15:14];
  assign addr_s    = rx_shift_r[13:8];
  assign data_s    = rx_shift_r[7:0];
  assign reg_hit_s = ({1'b0, addr_s} < NUM_REGS_W);
  assign wr_en_s   = (state_r == PROCESS) && (opcode_s == 2'b01) && reg_hit_s;

  // Decode the received command into the response word for the next frame.
  always_comb begin
    rd_val_s = 8'h00;
    resp_s   = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val_s = (addr_s == 6'(i)) ? regs_r[i] : rd_val_s;
    end
    case (opcode_s)
      2'b00: begin
        if (addr_s == ID_ADDR) begin
          resp_s = {8'h00, CHIP_ID};
        end else if (reg_hit_s) begin
          resp_s = {8'h00, rd_val_s};
        end else begin
          resp_s = 16'h0000;
        end
      end
      2'b01:   resp_s = {8'hFF, data_s};
      2'b10:   resp_s = {addr_s, sample_cnt_r};
      2'b11:   resp_s = 16'h0000;
      default: resp_s = 16'h0000;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame sequencing: a 16th SCLK rise completes the frame; any later rise is an overrun.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_IDLE: state_next_s = cs_high_s ? IDLE : WAIT_IDLE;
      IDLE:      state_next_s = cs_fall_s ? ACTIVE : IDLE;
      ACTIVE: begin
        if (cs_rise_s) begin
          state_next_s = ERROR;
        end else if (sclk_rise_s && (bit_cnt_r == 5'd15)) begin
          state_next_s = COMPLETE;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      COMPLETE: begin
        if (cs_rise_s) begin
          state_next_s = (overrun_r || sclk_rise_s) ? ERROR : PROCESS;
        end else begin
          state_next_s = COMPLETE;
        end
      end
      PROCESS: state_next_s = IDLE;
      ERROR:   state_next_s = IDLE;
      default: state_next_s = WAIT_IDLE;
    endcase
  end

  // Shift registers, response pipeline, strobes and convert counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift_r    <= 16'h0000;
      rx_shift_r    <= 16'h0000;
      pending_r     <= 16'h0000;
      rx_word_r     <= 16'h0000;
      bit_cnt_r     <= 5'd0;
      overrun_r     <= 1'b0;
      miso_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_error_r <= 1'b0;
      sample_cnt_r  <= 10'd0;
    end else begin
      frame_done_r  <= 1'b0;
      frame_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            tx_shift_r <= pending_r;
            miso_r     <= pending_r[15];
            rx_shift_r <= 16'h0000;
            bit_cnt_r  <= 5'd0;
            overrun_r  <= 1'b0;
          end else begin
            miso_r <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise_s) begin
            miso_r <= 1'b0;
          end else if (sclk_rise_s) begin
            rx_shift_r <= {rx_shift_r[14:0], mosi_s};
            bit_cnt_r  <= bit_cnt_r + 5'd1;
            if (bit_cnt_r == 5'd15) begin
              miso_r <= 1'b0;
            end
          end else if (sclk_fall_s) begin
            tx_shift_r <= {tx_shift_r[14:0], 1'b0};
            miso_r     <= tx_shift_r[14];
          end
        end
        COMPLETE: begin
          miso_r <= 1'b0;
          if (sclk_rise_s) begin
            overrun_r <= 1'b1;
          end
        end
        PROCESS: begin
          rx_word_r    <= rx_shift_r;
          frame_done_r <= 1'b1;
          pending_r    <= resp_s;
          if (opcode_s == 2'b10) begin
            sample_cnt_r <= sample_cnt_r + 10'd1;
          end
        end
        ERROR: begin
          frame_error_r <= 1'b1;
          pending_r     <= ERR_WORD;
        end
        default: miso_r <= 1'b0;
      endcase
    end
  end

  // Config register file; writes land in PROCESS so a following read sees them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_s == 6'(i)) begin
          regs_r[i] <= data_s;
        end
      end
    end
  end

  assign MISO_from_sensor = miso_r;
  assign rx_word          = rx_word_r;
  assign frame_done       = frame_done_r;
  assign frame_error      = frame_error_r;
  assign sample_cnt       = sample_cnt_r;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: a table of full frames with the response
// expected on MISO in each frame, then hand-written error, wrap and mid-frame reset cases.
module tb_spi_sensor_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK_wire;
  logic        CS_b_wire;
  logic        MOSI_to_sensor;
  logic        MISO_from_sensor;
  logic [15:0] rx_word;
  logic        frame_done;
  logic        frame_error;
  logic [9:0]  sample_cnt;

  spi_sensor_responder dut (
    .clk              (clk),
    .reset            (reset),
    .SCLK_wire        (SCLK_wire),
    .CS_b_wire        (CS_b_wire),
    .MOSI_to_sensor   (MOSI_to_sensor),
    .MISO_from_sensor (MISO_from_sensor),
    .rx_word          (rx_word),
    .frame_done       (frame_done),
    .frame_error      (frame_error),
    .sample_cnt       (sample_cnt)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int err_cnt      = 0;

  // Count strobe pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
  end

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t vecs [16];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side of one frame: nbits SCLK pulses, MISO captured just before each rise.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] miso_word);
    logic [15:0] sh;
    sh = cmd;
    miso_word = 16'h0000;
    CS_b_wire = 1'b0;
    clks(6);
    for (int i = 0; i < nbits; i++) begin
      MOSI_to_sensor = sh[15];
      sh = {sh[14:0], 1'b0};
      clks(5);
      if (i < 16) miso_word = {miso_word[14:0], MISO_from_sensor};
      SCLK_wire = 1'b1;
      clks(5);
      SCLK_wire = 1'b0;
    end
    clks(5);
    CS_b_wire = 1'b1;
    MOSI_to_sensor = 1'b0;
    clks(8);
  endtask

  // Full 16-bit frame with checks on the returned response, rx_word and frame_done.
  task automatic good_frame(input string name, input logic [15:0] cmd, input logic [15:0] exp_miso);
    logic [15:0] m;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(cmd, 16, m);
    check16({name, " miso"}, m, exp_miso);
    check16({name, " rx_word"}, rx_word, cmd);
    check16({name, " done pulses"}, 16'(done_cnt - d0), 16'd1);
    check16({name, " error pulses"}, 16'(err_cnt - e0), 16'd0);
  endtask

  // Short or long frame that must be rejected.
  task automatic bad_frame(input string name, input logic [15:0] cmd, input int nbits,
                           input logic [15:0] rx_keep, output logic [15:0] m);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(cmd, nbits, m);
    check16({name, " error pulses"}, 16'(err_cnt - e0), 16'd1);
    check16({name, " done pulses"}, 16'(done_cnt - d0), 16'd0);
    check16({name, " rx_word kept"}, rx_word, rx_keep);
  endtask

  initial begin
    logic [15:0] m;
    logic        miso_seen;
    int          d0, e0;

    vecs[0]  = '{16'h0000, 16'h0000};  // READ 0, reset response
    vecs[1]  = '{16'h4312, 16'h0000};  // WRITE 3 <= 12, resp of READ 0
    vecs[2]  = '{16'h0300, 16'hFF12};  // READ 3, resp of WRITE
    vecs[3]  = '{16'h3F00, 16'h0012};  // READ 63, resp of READ 3
    vecs[4]  = '{16'h7F99, 16'h005A};  // WRITE 63 (read-only), chip id
    vecs[5]  = '{16'h3F00, 16'hFF99};  // READ 63, resp of WRITE 63
    vecs[6]  = '{16'h8500, 16'h005A};  // CONVERT 5, chip id unchanged
    vecs[7]  = '{16'h8500, 16'h1400};
    vecs[8]  = '{16'h8500, 16'h1401};
    vecs[9]  = '{16'hC000, 16'h1402};  // NOP
    vecs[10] = '{16'h4FAB, 16'h0000};  // WRITE 15 (last reg)
    vecs[11] = '{16'h0F00, 16'hFFAB};  // READ 15
    vecs[12] = '{16'h1000, 16'h00AB};  // READ 16 (out of range)
    vecs[13] = '{16'h5077, 16'h0000};  // WRITE 16 ignored
    vecs[14] = '{16'h1000, 16'hFF77};  // READ 16
    vecs[15] = '{16'hC000, 16'h0000};  // NOP, out-of-range read gave 0

    reset          = 1'b0;
    SCLK_wire      = 1'b0;
    CS_b_wire      = 1'b1;
    MOSI_to_sensor = 1'b0;
    clks(4);
    check16("reset miso", 16'(MISO_from_sensor), 16'd0);
    check16("reset rx_word", rx_word, 16'h0000);
    check16("reset done", 16'(frame_done), 16'd0);
    check16("reset error", 16'(frame_error), 16'd0);
    check16("reset sample_cnt", 16'(sample_cnt), 16'd0);
    reset = 1'b1;
    clks(6);

    for (int i = 0; i < 16; i++) begin
      good_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].exp_miso);
    end
    check16("sample_cnt after 3 converts", 16'(sample_cnt), 16'd3);

    // Aborted write after 9 bits, then a 17-clock frame; neither may change reg 3.
    bad_frame("short frame", 16'h4321, 9, 16'hC000, m);
    good_frame("after short", 16'hC000, 16'hDEAD);
    bad_frame("long frame", 16'h0300, 17, 16'hC000, m);
    check16("long frame miso", m, 16'h0000);
    good_frame("after long", 16'h0300, 16'hDEAD);
    good_frame("reg3 kept", 16'hC000, 16'h0012);

    // Convert counter wrap from its top value.
    force dut.sample_cnt_r = 10'd1023;
    clks(2);
    release dut.sample_cnt_r;
    clks(1);
    check16("preload sample_cnt", 16'(sample_cnt), 16'd1023);
    good_frame("convert at 1023", 16'h8500, 16'h0000);
    check16("sample_cnt wrapped", 16'(sample_cnt), 16'd0);
    good_frame("wrap response", 16'hC000, 16'h17FF);

    // Reset in the middle of a frame with CS_b held low.
    good_frame("write reg1", 16'h4155, 16'h0000);
    d0 = done_cnt;
    e0 = err_cnt;
    CS_b_wire = 1'b0;
    clks(6);
    for (int i = 0; i < 7; i++) begin
      MOSI_to_sensor = 1'b1;
      clks(5);
      SCLK_wire = 1'b1;
      clks(5);
      SCLK_wire = 1'b0;
    end
    reset = 1'b0;
    clks(3);
    check16("midreset rx_word", rx_word, 16'h0000);
    reset = 1'b1;
    clks(2);
    miso_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      MOSI_to_sensor = 1'b1;
      clks(5);
      miso_seen = miso_seen | MISO_from_sensor;
      SCLK_wire = 1'b1;
      clks(5);
      miso_seen = miso_seen | MISO_from_sensor;
      SCLK_wire = 1'b0;
    end
    clks(5);
    check16("midreset miso quiet", 16'(miso_seen), 16'd0);
    CS_b_wire = 1'b1;
    MOSI_to_sensor = 1'b0;
    clks(8);
    check16("midreset no done", 16'(done_cnt - d0), 16'd0);
    check16("midreset no error", 16'(err_cnt - e0), 16'd0);
    good_frame("after reset", 16'h0100, 16'h0000);
    good_frame("reg1 cleared", 16'hC000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
